bram_fifo_ctrl: RTL

Synchronous first-word-fall-through FIFO controller that owns the write and read pointers for the simple dual-port `BRAM_WRAPPER` storage block (registered read address, one-cycle read) and instantiates it. It sits on the DMA datapath between a producer (for example, the PSL response/data capture logic) and a consumer engine. It turns strobe-style push/pop into a FIFO with full/empty/almost-full status and occupancy count. It hides the RAM read latency: the head entry is always present on `pop_data_o` while not empty.

---
 rtl/dma_fifo_pkg.sv | 18 +
 rtl/BRAM_WRAPPER.sv | 31 +++
 rtl/bram_fifo_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dma_fifo_pkg.sv
// Shared DMA FIFO definitions: the depth expression and the status-flag bit
// ordering that every DMA FIFO uses when it packs its status into a vector.
package dma_fifo_pkg;

   // Bit positions inside a packed FIFO status vector
   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_AFULL = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_UDF   = 4;
   localparam int STAT_W     = 5;

   // FIFO depth for a given address width
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/BRAM_WRAPPER.sv
// Simple dual-port storage: one synchronous write port and one read port whose
// address is registered. Read data follows the registered address, so data
// for the address presented at edge T is available right after T. Contents
// are never reset.
module BRAM_WRAPPER #(
   parameter int aw = 3,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [aw-1:0] waddr,
   input  logic [dw-1:0] wdata,
   input  logic [aw-1:0] raddr,
   output logic [dw-1:0] rdata
);

   logic [dw-1:0] mem [0:(1<<aw)-1];
   logic [aw-1:0] raddr_reg;

   // Write port and read-address register; a write and a read of the same
   // address at one edge returns the new data after that edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      raddr_reg <= raddr;
   end

   assign rdata = mem[raddr_reg];

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around BRAM_WRAPPER. Owns the write
// and read pointers, occupancy count and optional sticky error flags.
// Optional feature macro: BRAM_FIFO_ERR_EN (sticky ovf_o/udf_o flags).
// The RAM read address is fed with the next read pointer so the registered
// RAM address always equals the current read pointer and the head entry sits
// on pop_data_o without a bubble.
module bram_fifo_ctrl
   import dma_fifo_pkg::*;
#(
   parameter int AW        = 3,
   parameter int DW        = 8,
   parameter int AFULL_THR = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] pop_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          afull_o,
   output logic [AW:0]   count_o,
   output logic          ovf_o,
   output logic          udf_o
);

   localparam int DEPTH = fifo_depth(AW);

   logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [AW:0]       count_reg, count_next;
   logic              push_acc, pop_acc, ram_we;
   logic              ovf_flag, udf_flag;
   logic [STAT_W-1:0] status;

   // Status decodes of registered state only
   assign status[STAT_EMPTY] = (count_reg == '0);
   assign status[STAT_FULL]  = (count_reg == (AW+1)'(DEPTH));
   assign status[STAT_AFULL] = (count_reg >= (AW+1)'(AFULL_THR));
   assign status[STAT_OVF]   = ovf_flag;
   assign status[STAT_UDF]   = udf_flag;

   // Accept decisions and next-state for pointers and count; flush wins
   always_comb begin
      push_acc    = push_i & (~status[STAT_FULL] | pop_i);
      pop_acc     = pop_i & ~status[STAT_EMPTY];
      ram_we      = push_acc & ~flush_i;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         wr_ptr_next = wr_ptr_reg + AW'(push_acc);
         rd_ptr_next = rd_ptr_reg + AW'(pop_acc);
         case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

`ifdef BRAM_FIFO_ERR_EN
   logic ovf_reg, udf_reg;

   // Sticky overflow/underflow flags, cleared by reset or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
         udf_reg <= 1'b0;
      end else if (flush_i) begin
         ovf_reg <= 1'b0;
         udf_reg <= 1'b0;
      end else begin
         if (push_i & status[STAT_FULL] & ~pop_i) ovf_reg <= 1'b1;
         if (pop_i & status[STAT_EMPTY])          udf_reg <= 1'b1;
      end
   end

   assign ovf_flag = ovf_reg;
   assign udf_flag = udf_reg;
`else
   assign ovf_flag = 1'b0;
   assign udf_flag = 1'b0;
`endif

   BRAM_WRAPPER #(
      .aw (AW),
      .dw (DW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_reg),
      .wdata (push_data_i),
      .raddr (rd_ptr_next),
      .rdata (pop_data_o)
   );

   assign empty_o = status[STAT_EMPTY];
   assign full_o  = status[STAT_FULL];
   assign afull_o = status[STAT_AFULL];
   assign ovf_o   = status[STAT_OVF];
   assign udf_o   = status[STAT_UDF];
   assign count_o = count_reg;

endmodule
